// File: rtl/lane_sync_ctrl.sv
// lane_sync_ctrl
// ---------------------------------------------------------------------------
// Receive-lane sequencing controller in the clk_4f domain. It sits directly
// after the 8-bit symbol deserializer.
//   * HUNT/CONFIRM: looks for SYNC_CNT consecutive clean comma symbols.
//   * ACTIVE: forwards data symbols with a one-cycle valid strobe.
//   * IDLE: the lane is receiving idle symbols.
//   * LOSS_CNT consecutive errored symbols in ACTIVE/IDLE drop sync, pulse
//     sync_lost and return to HUNT.
//
// Optional build macro: LANE_SYNC_STATS_EN adds err_total, a saturating
// 16-bit count of errored valid symbols. The counter is cleared only by reset.
//
// Ports
//   clk_4f      in   1  block clock, rising edge
//   reset       in   1  asynchronous, active-high reset
//   sym_in      in   8  parallel symbol from the deserializer
//   sym_valid   in   1  sym_in/sym_err are valid this cycle
//   sym_err     in   1  decoder error flag for sym_in
//   data_out    out  8  forwarded data symbol (holds when valid_out=0)
//   valid_out   out  1  one-cycle strobe per forwarded symbol
//   idle_out    out  1  lane is in idle
//   active_out  out  1  lane is synced (ACTIVE or IDLE)
//   sync_lost   out  1  one-cycle pulse on loss of sync
//   err_total   out 16  saturating error count (LANE_SYNC_STATS_EN only)
//   state_out   out  2  HUNT=0, CONFIRM=1, ACTIVE=2, IDLE=3
//
// Handshake: a symbol is consumed on a rising edge where sym_valid=1. There is
// no back-pressure. The response is registered and appears one cycle later.
// In cycles where sym_valid=0, the state and counters hold, and valid_out and
// sync_lost are low.
// ---------------------------------------------------------------------------
module lane_sync_ctrl #(
    parameter int unsigned SYNC_CNT  = 4,
    parameter int unsigned LOSS_CNT  = 3,
    parameter logic [7:0]  COMMA_SYM = 8'hBC,
    parameter logic [7:0]  IDLE_SYM  = 8'h7C
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic [7:0]  sym_in,
    input  logic        sym_valid,
    input  logic        sym_err,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic        idle_out,
    output logic        active_out,
    output logic        sync_lost,
`ifdef LANE_SYNC_STATS_EN
    output logic [15:0] err_total,
`endif
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_IDLE    = 2'd3
    } state_t;

    localparam logic [3:0] SYNC_TGT = 4'(SYNC_CNT);
    localparam logic [3:0] LOSS_TGT = 4'(LOSS_CNT);

    state_t      state_q,  state_d;
    logic [3:0]  bc_cnt_q, bc_cnt_d;
    logic [3:0]  err_cnt_q, err_cnt_d;
    logic [7:0]  data_q,   data_d;
    logic        valid_q,  valid_d;
    logic        idle_q,   idle_d;
    logic        active_q, active_d;
    logic        lost_q,   lost_d;

    logic        is_comma;
    logic        is_idle;
    logic [3:0]  bc_inc;
    logic [3:0]  err_inc;

    assign is_comma = (sym_in == COMMA_SYM);
    assign is_idle  = (sym_in == IDLE_SYM);
    assign bc_inc   = bc_cnt_q + 4'd1;
    assign err_inc  = err_cnt_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        bc_cnt_d  = bc_cnt_q;
        err_cnt_d = err_cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        idle_d    = idle_q;
        lost_d    = 1'b0;

        if (sym_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (is_comma && !sym_err) begin
                        if (SYNC_TGT == 4'd1) begin
                            state_d  = ST_ACTIVE;
                            bc_cnt_d = 4'd0;
                        end else begin
                            state_d  = ST_CONFIRM;
                            bc_cnt_d = 4'd1;
                        end
                    end else begin
                        bc_cnt_d = 4'd0;
                    end
                end

                ST_CONFIRM: begin
                    if (is_comma && !sym_err) begin
                        if (bc_inc == SYNC_TGT) begin
                            state_d  = ST_ACTIVE;
                            bc_cnt_d = 4'd0;
                        end else begin
                            bc_cnt_d = bc_inc;
                        end
                    end else begin
                        state_d  = ST_HUNT;
                        bc_cnt_d = 4'd0;
                    end
                end

                ST_ACTIVE, ST_IDLE: begin
                    // An error overrides decode. In IDLE, the state and idle
                    // flag hold until the loss threshold is reached.
                    if (sym_err) begin
                        if (err_inc == LOSS_TGT) begin
                            state_d   = ST_HUNT;
                            err_cnt_d = 4'd0;
                            bc_cnt_d  = 4'd0;
                            idle_d    = 1'b0;
                            lost_d    = 1'b1;
                        end else begin
                            err_cnt_d = err_inc;
                        end
                    end else begin
                        err_cnt_d = 4'd0;
                        if (is_idle) begin
                            state_d = ST_IDLE;
                            idle_d  = 1'b1;
                        end else if (!is_comma) begin
                            // A data symbol forwards and leaves IDLE in the
                            // same cycle. A comma leaves the state as it is.
                            state_d = ST_ACTIVE;
                            idle_d  = 1'b0;
                            data_d  = sym_in;
                            valid_d = 1'b1;
                        end
                    end
                end

                default: state_d = ST_HUNT;
            endcase
        end

        active_d = (state_d == ST_ACTIVE) || (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state_q   <= ST_HUNT;
            bc_cnt_q  <= 4'd0;
            err_cnt_q <= 4'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            idle_q    <= 1'b0;
            active_q  <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bc_cnt_q  <= bc_cnt_d;
            err_cnt_q <= err_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            idle_q    <= idle_d;
            active_q  <= active_d;
            lost_q    <= lost_d;
        end
    end

    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign idle_out   = idle_q;
    assign active_out = active_q;
    assign sync_lost  = lost_q;
    assign state_out  = state_q;

`ifdef LANE_SYNC_STATS_EN
    logic [15:0] err_total_q, err_total_d;

    // The counter counts errored valid symbols in any state and saturates
    // instead of wrapping.
    always_comb begin
        err_total_d = err_total_q;
        if (sym_valid && sym_err && (err_total_q != 16'hFFFF)) begin
            err_total_d = err_total_q + 16'd1;
        end
    end

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            err_total_q <= 16'd0;
        end else begin
            err_total_q <= err_total_d;
        end
    end

    assign err_total = err_total_q;
`endif

endmodule

// File: tb/tb_lane_sync_ctrl.sv
module tb_lane_sync_ctrl;
  localparam int SYNC = 4;
  localparam int LOSS = 3;
  localparam logic [7:0] BC = 8'hBC;
  localparam logic [7:0] IDL = 8'h7C;

  // ---------------- clock / reset / dut ----------------
  logic clk_4f = 1'b0;
  logic reset;
  logic [7:0] sym_in;
  logic sym_valid, sym_err;
  logic [7:0] data_out;
  logic valid_out, idle_out, active_out, sync_lost;
  logic [1:0] state_out;
`ifdef LANE_SYNC_STATS_EN
  logic [15:0] err_total;
`endif

  always #5 clk_4f = ~clk_4f;

  lane_sync_ctrl dut (
    .clk_4f(clk_4f),
    .reset(reset),
    .sym_in(sym_in),
    .sym_valid(sym_valid),
    .sym_err(sym_err),
    .data_out(data_out),
    .valid_out(valid_out),
    .idle_out(idle_out),
    .active_out(active_out),
    .sync_lost(sync_lost),
`ifdef LANE_SYNC_STATS_EN
    .err_total(err_total),
`endif
    .state_out(state_out)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  // ---------------- reference model ----------------
  // The lane is described by: whether it is synced, how many clean commas
  // have been seen in the current run, whether it is idling, and the length
  // of the current run of errored symbols.
  bit m_sync, m_idle, m_valid, m_lost;
  int m_commas, m_errs, m_stats;
  logic [7:0] m_data;

  function automatic void model_reset();
    m_sync = 0; m_idle = 0; m_valid = 0; m_lost = 0;
    m_commas = 0; m_errs = 0; m_stats = 0; m_data = 8'h00;
    exp_q.delete();
  endfunction

  function automatic void model_step(logic [7:0] s, bit e, bit v);
    m_valid = 0;
    m_lost = 0;
    if (!v) return;
    if (e && m_stats < 65535) m_stats = m_stats + 1;
    if (!m_sync) begin
      if (s == BC && !e) begin
        m_commas = m_commas + 1;
        if (m_commas >= SYNC) begin
          m_sync = 1; m_idle = 0; m_commas = 0; m_errs = 0;
        end
      end else begin
        m_commas = 0;
      end
    end else if (e) begin
      m_errs = m_errs + 1;
      if (m_errs >= LOSS) begin
        m_sync = 0; m_idle = 0; m_errs = 0; m_commas = 0; m_lost = 1;
      end
    end else begin
      m_errs = 0;
      if (s == IDL) m_idle = 1;
      else if (s != BC) begin
        m_idle = 0; m_valid = 1; m_data = s;
        exp_q.push_back(s);
      end
    end
  endfunction

  function automatic logic [1:0] m_state();
    if (!m_sync) return (m_commas > 0) ? 2'd1 : 2'd0;
    return m_idle ? 2'd3 : 2'd2;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk_4f);
    reset = 1'b1; sym_valid = 1'b0; sym_err = 1'b0; sym_in = 8'h00;
    model_reset();
    repeat (2) @(negedge clk_4f);
    reset = 1'b0;
  endtask

  task automatic cycle(input logic [7:0] s, input bit e, input bit v);
    @(negedge clk_4f);
    sym_in = s; sym_err = e; sym_valid = v;
    @(posedge clk_4f);
    #1;
    model_step(s, e, v);
  endtask

  task automatic go_sync();
    do_reset();
    repeat (SYNC) cycle(BC, 1'b0, 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_out); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    checks++; if (idle_out !== 1'b0) begin errors++; $display("FAIL reset_idle: got %b want 0", idle_out); end
    checks++; if (active_out !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", active_out); end
    checks++; if (sync_lost !== 1'b0) begin errors++; $display("FAIL reset_lost: got %b want 0", sync_lost); end
  endtask

  task automatic test_sync_entry();
    logic [1:0] want;
    do_reset();
    for (int i = 0; i < SYNC; i++) begin
      cycle(BC, 1'b0, 1'b1);
      want = (i == SYNC - 1) ? 2'd2 : 2'd1;
      checks++; if (state_out !== want) begin errors++; $display("FAIL sync_state[%0d]: got %0d want %0d", i, state_out, want); end
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL sync_valid[%0d]: got %b want 0", i, valid_out); end
    end
    checks++; if (active_out !== 1'b1) begin errors++; $display("FAIL sync_active: got %b want 1", active_out); end
  endtask

  task automatic test_broken_run();
    do_reset();
    repeat (3) cycle(BC, 1'b0, 1'b1);
    cycle(8'h55, 1'b0, 1'b1);
    checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL broken_hunt: got %0d want 0", state_out); end
    for (int i = 0; i < SYNC; i++) begin
      cycle(BC, 1'b0, 1'b1);
      checks++; if (state_out !== m_state()) begin errors++; $display("FAIL broken_state[%0d]: got %0d want %0d", i, state_out, m_state()); end
      checks++; if (active_out !== m_sync) begin errors++; $display("FAIL broken_active[%0d]: got %b want %b", i, active_out, m_sync); end
    end
  endtask

  task automatic test_idle();
    go_sync();
    cycle(8'hA1, 1'b0, 1'b1);
    checks++; if (valid_out !== 1'b1 || data_out !== 8'hA1) begin errors++; $display("FAIL idle_a1: got v=%b d=%h want v=1 d=a1", valid_out, data_out); end
    for (int i = 0; i < 2; i++) begin
      cycle(IDL, 1'b0, 1'b1);
      checks++; if (idle_out !== 1'b1 || valid_out !== 1'b0 || state_out !== 2'd3) begin
        errors++; $display("FAIL idle_hold[%0d]: got i=%b v=%b s=%0d want i=1 v=0 s=3", i, idle_out, valid_out, state_out); end
    end
    cycle(8'h3F, 1'b0, 1'b1);
    checks++; if (valid_out !== 1'b1 || data_out !== 8'h3F || idle_out !== 1'b0 || state_out !== 2'd2) begin
      errors++; $display("FAIL idle_exit: got v=%b d=%h i=%b s=%0d want v=1 d=3f i=0 s=2", valid_out, data_out, idle_out, state_out); end
    // an errored symbol in IDLE keeps IDLE
    cycle(IDL, 1'b0, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);
    checks++; if (state_out !== 2'd3 || idle_out !== 1'b1) begin errors++; $display("FAIL idle_err: got s=%0d i=%b want s=3 i=1", state_out, idle_out); end
    exp_q.delete();
  endtask

  task automatic test_loss();
    go_sync();
    for (int i = 0; i < LOSS; i++) begin
      cycle(8'h12, 1'b1, 1'b1);
      checks++; if (sync_lost !== (i == LOSS - 1)) begin errors++; $display("FAIL loss_pulse[%0d]: got %b want %b", i, sync_lost, (i == LOSS - 1)); end
    end
    checks++; if (state_out !== 2'd0 || active_out !== 1'b0 || valid_out !== 1'b0) begin
      errors++; $display("FAIL loss_state: got s=%0d a=%b v=%b want s=0 a=0 v=0", state_out, active_out, valid_out); end
    cycle(8'h00, 1'b0, 1'b1);
    checks++; if (sync_lost !== 1'b0) begin errors++; $display("FAIL loss_one_shot: got %b want 0", sync_lost); end
    // two errors then clean data: counter restarts
    go_sync();
    repeat (LOSS - 1) cycle(8'h12, 1'b1, 1'b1);
    cycle(8'h11, 1'b0, 1'b1);
    checks++; if (valid_out !== 1'b1 || data_out !== 8'h11 || state_out !== 2'd2) begin
      errors++; $display("FAIL loss_clean: got v=%b d=%h s=%0d want v=1 d=11 s=2", valid_out, data_out, state_out); end
    repeat (LOSS - 1) cycle(8'h12, 1'b1, 1'b1);
    checks++; if (sync_lost !== 1'b0 || active_out !== 1'b1) begin errors++; $display("FAIL loss_restart: got l=%b a=%b want l=0 a=1", sync_lost, active_out); end
    cycle(8'h12, 1'b1, 1'b1);
    checks++; if (sync_lost !== 1'b1 || state_out !== 2'd0) begin errors++; $display("FAIL loss_second: got l=%b s=%0d want l=1 s=0", sync_lost, state_out); end
    exp_q.delete();
  endtask

  task automatic test_gaps();
    logic [7:0] d;
    go_sync();
    for (int i = 0; i < 5; i++) begin
      d = 8'(16 * i + 3);
      cycle(d, 1'b0, 1'b1);
      checks++; if (valid_out !== 1'b1 || data_out !== d) begin errors++; $display("FAIL gap_data[%0d]: got v=%b d=%h want v=1 d=%h", i, valid_out, data_out, d); end
      cycle(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
      checks++; if (valid_out !== 1'b0 || data_out !== d || state_out !== 2'd2 || active_out !== 1'b1) begin
        errors++; $display("FAIL gap_hold[%0d]: got v=%b d=%h s=%0d a=%b want v=0 d=%h s=2 a=1", i, valid_out, data_out, state_out, active_out, d); end
    end
    // error counter holds across a gap that carries sym_err
    repeat (LOSS - 1) cycle(8'h12, 1'b1, 1'b1);
    cycle(8'h12, 1'b1, 1'b0);
    checks++; if (sync_lost !== 1'b0 || state_out !== 2'd2) begin errors++; $display("FAIL gap_err_hold: got l=%b s=%0d want l=0 s=2", sync_lost, state_out); end
    cycle(8'h12, 1'b1, 1'b1);
    checks++; if (sync_lost !== 1'b1) begin errors++; $display("FAIL gap_err_loss: got %b want 1", sync_lost); end
    // comma count holds across a gap
    repeat (2) cycle(BC, 1'b0, 1'b1);
    cycle(8'h55, 1'b0, 1'b0);
    checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL gap_confirm: got %0d want 1", state_out); end
    repeat (SYNC - 2) cycle(BC, 1'b0, 1'b1);
    checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL gap_confirm_sync: got %0d want 2", state_out); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    go_sync();
    cycle(8'h9A, 1'b0, 1'b1);
    cycle(IDL, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (state_out !== 2'd0 || active_out !== 1'b0 || idle_out !== 1'b0 || data_out !== 8'h00 || valid_out !== 1'b0 || sync_lost !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got s=%0d a=%b i=%b d=%h v=%b l=%b want all 0", state_out, active_out, idle_out, data_out, valid_out, sync_lost); end
    @(negedge clk_4f);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic [7:0] s, want;
    bit e, v;
    int r;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 5);
      s = (r < 2) ? BC : (r == 2) ? IDL : 8'($urandom_range(0, 255));
      e = ($urandom_range(0, 6) == 0);
      v = ($urandom_range(0, 9) != 0);
      cycle(s, e, v);
      checks++; if (state_out !== m_state() || active_out !== m_sync || idle_out !== m_idle || sync_lost !== m_lost || valid_out !== m_valid) begin
        errors++; $display("FAIL rand[%0d]: got s=%0d a=%b i=%b l=%b v=%b want s=%0d a=%b i=%b l=%b v=%b", i,
          state_out, active_out, idle_out, sync_lost, valid_out, m_state(), m_sync, m_idle, m_lost, m_valid); end
      if (valid_out === 1'b1) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (data_out !== want) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", i, data_out, want); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d pending want 0", exp_q.size()); end
    exp_q.delete();
  endtask

`ifdef LANE_SYNC_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(8'h44, 1'b1, 1'b1);
      cycle(8'h44, 1'b1, 1'b0);
    end
    checks++; if (err_total !== 16'd5) begin errors++; $display("FAIL stats_count: got %0d want 5", err_total); end
    @(negedge clk_4f);
    force dut.err_total_q = 16'hFFFD;
    #1;
    release dut.err_total_q;
    m_stats = 16'hFFFD;
    repeat (4) cycle(8'h44, 1'b1, 1'b1);
    checks++; if (err_total !== 16'(m_stats) || err_total !== 16'hFFFF) begin errors++; $display("FAIL stats_sat: got %h want ffff", err_total); end
  endtask
`endif

  initial begin
    reset = 1'b1; sym_in = 8'h00; sym_valid = 1'b0; sym_err = 1'b0;
    model_reset();
    test_reset();
    test_sync_entry();
    test_broken_run();
    test_idle();
    test_loss();
    test_gaps();
    test_reset_mid();
    test_random();
`ifdef LANE_SYNC_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog: every wait in this bench is a fixed number of clock edges.
  // This limit only catches a stalled clock.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/lane_sync_ctrl.md
Name: lane_sync_ctrl

Overview:
Receive-lane sequencing controller that sits directly after the 8-bit symbol deserializer, in the clk_4f domain.
- Hunts for comma (BC) symbols and declares lane sync after a run of consecutive commas.
- Once synced, forwards data symbols with a valid strobe and flags idle (7C) periods.
- Drops sync after repeated symbol errors and returns to the hunt state.

Parameters:
SYNC_CNT, 4, consecutive commas required to enter ACTIVE (legal range 1..15)
LOSS_CNT, 3, consecutive errored symbols in ACTIVE/IDLE that force loss of sync (legal range 1..15)
COMMA_SYM, 8'hBC, comma/alignment symbol
IDLE_SYM, 8'h7C, idle symbol

Ports:
clk_4f  input  1  block clock; all flops on rising edge
reset  input  1  asynchronous, active-high reset
sym_in  input  8  parallel symbol from deserializer
sym_valid  input  1  sym_in/sym_err valid this cycle; when low the cycle is ignored
sym_err  input  1  decoder error flag for sym_in
data_out  output  8  forwarded data symbol
valid_out  output  1  data_out valid, one-cycle strobe per symbol
idle_out  output  1  lane currently in idle
active_out  output  1  lane synced (state ACTIVE or IDLE)
sync_lost  output  1  one-cycle pulse on loss of sync
state_out  output  2  current state encoding

Behaviour:
- Reset (async, active-high): state=HUNT, bc_cnt=0, err_cnt=0, data_out=8'h00, valid_out=0, idle_out=0, active_out=0, sync_lost=0. Reset asserted mid-operation clears everything immediately, with no completion of in-flight symbols.
- All outputs are registered. The response to a symbol sampled on edge N appears after edge N, i.e. one-cycle latency.
- sym_valid=0: state, bc_cnt and err_cnt hold; valid_out=0 and sync_lost=0 the next cycle; idle_out and active_out hold.
- State encoding: HUNT=2'd0, CONFIRM=2'd1, ACTIVE=2'd2, IDLE=2'd3.
- HUNT:
  - comma and !sym_err -> CONFIRM, bc_cnt=1. If SYNC_CNT==1, go straight to ACTIVE.
  - Anything else: stay in HUNT, bc_cnt=0.
- CONFIRM:
  - comma and !sym_err: bc_cnt+1. When the incremented value equals SYNC_CNT -> ACTIVE, bc_cnt=0.
  - Non-comma or sym_err -> HUNT, bc_cnt=0.
  - bc_cnt is 4 bits wide and never exceeds SYNC_CNT.
- ACTIVE:
  - Data symbol (not comma, not idle, !sym_err): data_out=sym_in, valid_out=1, err_cnt=0.
  - Comma: no output, err_cnt=0, stay in ACTIVE.
  - Idle symbol: -> IDLE, idle_out=1, err_cnt=0, no valid_out.
- IDLE:
  - Idle or comma symbol: stay in IDLE, idle_out=1.
  - Data symbol: -> ACTIVE, idle_out=0, and the symbol is forwarded in the same transition (valid_out=1).
- Errors (ACTIVE/IDLE):
  - sym_err=1 takes priority over symbol decode: no forwarding, err_cnt+1.
  - When err_cnt reaches LOSS_CNT -> HUNT; sync_lost=1 for one cycle; active_out=0, idle_out=0; err_cnt=0, bc_cnt=0.
  - A clean symbol resets err_cnt.
  - An errored symbol in IDLE keeps the state IDLE, with idle_out held, until loss.
- Outputs vs state:
  - active_out=1 exactly when the registered state is ACTIVE or IDLE.
  - data_out holds its last value when valid_out=0.

Optional Feature:
LANE_SYNC_STATS_EN:
- Defined: adds output err_total (16 bits), a count of sym_err=1 && sym_valid=1 cycles in any state.
  - Saturates at 16'hFFFF and does not wrap.
  - Cleared only by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then 4x BC with sym_valid=1 -> state 0->1->1->1->2; active_out=1 the cycle after the 4th BC; valid_out stays 0 throughout.
- 3x BC, then 8'h55, then 4x BC -> returns to HUNT after 8'h55 (state_out=0); ACTIVE is reached only after the second full run.
- Synced, send 8'hA1, 8'h7C, 8'h7C, 8'h3F -> valid_out pulses with data_out=A1, then idle_out=1 for two cycles, then valid_out with data_out=3F and idle_out=0.
- Synced, 3 consecutive sym_err=1 -> sync_lost pulses once after the 3rd error; state_out=0; active_out=0. Also: 2 errors then a clean data symbol -> no loss, and err_cnt restarts from 0.
- Synced, interleave sym_valid=0 gaps between data symbols -> no valid_out during gaps; state and counters are unchanged. Reset asserted while in ACTIVE -> all outputs return to reset values immediately.
- LANE_SYNC_STATS_EN defined: 5 errored valid symbols -> err_total=5. Force the counter near 16'hFFFF -> it holds at 16'hFFFF.
